// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake and serial line between a uart_tx and its user
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    modport master (output tx_start, tx_data, input tx, tx_ready, tx_busy, tx_done);
    modport slave (input tx_start, tx_data, output tx, tx_ready, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: start, 8 data bits MSB first, even parity, stop; CLKS_PER_BIT clocks per bit
module uart_tx #(
    parameter int CLKS_PER_BIT = 14
) (
    input logic       clk_3125,
    input logic       rst,
    uart_tx_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic par_q, par_d;
    logic tx_q, tx_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic last;
    always_comb begin
        last = cnt_q == LAST;
        state_d = state_q;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        bit_d = bit_q;
        sh_d = sh_q;
        par_d = par_q;
        case (state_q)
            IDLE: cnt_d = '0;
            START: if (last) begin
                state_d = DATA;
                bit_d = '0;
            end
            DATA: if (last) begin
                state_d = bit_q == 3'd7 ? PARITY : DATA;
                bit_d = bit_q + 3'd1;
                sh_d = {sh_q[6:0], 1'b0};
            end
            PARITY: if (last) state_d = STOP;
            STOP: if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // ready_q is high in IDLE and on the final stop clock, so back-to-back frames have no gap
        if (bus.tx_start && ready_q) begin
            state_d = START;
            cnt_d = '0;
            sh_d = bus.tx_data;
            par_d = ^bus.tx_data;
        end
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[7] : state_d == PARITY ? par_d : 1'b1;
        busy_d = state_d != IDLE;
        done_d = state_d == STOP && cnt_d == LAST;
        ready_d = state_d == IDLE || done_d;
    end
    always_ff @(posedge clk_3125) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            sh_q <= '0;
            par_q <= 1'b0;
            tx_q <= 1'b1;
            ready_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q <= sh_d;
            par_q <= par_d;
            tx_q <= tx_d;
            ready_q <= ready_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign bus.tx = tx_q;
    assign bus.tx_ready = ready_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame vectors, corner sequences and random bytes against a frame-level model
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int CPB = 14;
    localparam int FLEN = 11 * CPB;
    logic clk_3125 = 1'b0;
    logic rst;
    int tests = 0;
    int failed = 0;
    uart_tx_if bus ();
    uart_tx #(.CLKS_PER_BIT(CPB)) dut (.clk_3125(clk_3125), .rst(rst), .bus(bus));
    always #160 clk_3125 = ~clk_3125;
    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
        logic        par;
    } vec_t;
    vec_t vecs[9];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [10:0] model(input logic [7:0] b);
        int ones = $countones(b);
        return {1'b0, b, 1'(ones % 2), 1'b1};
    endfunction
    task automatic chk_idle(input string nm);
        chk(nm, {28'd0, bus.tx, bus.tx_ready, bus.tx_busy, bus.tx_done}, 32'b1100);
    endtask
    // Samples one whole frame, starting at the negedge of its first start-bit clock.
    task automatic run_frame(input string nm, input logic [10:0] exp, input bit hold,
                             input logic [7:0] nxt, input int inj);
        logic [10:0] fr = '0;
        int busy_n = 0, done_n = 0, done_at = -1, unstable = 0, ready_bad = 0;
        for (int k = 0; k < FLEN; k++) begin
            if (k % CPB == 0) fr[10 - k / CPB] = bus.tx;
            else if (bus.tx !== fr[10 - k / CPB]) unstable++;
            if (bus.tx_busy === 1'b1) busy_n++;
            if (bus.tx_done === 1'b1) begin
                done_n++;
                done_at = k;
            end
            if (bus.tx_ready !== (k == FLEN - 1)) ready_bad++;
            bus.tx_start = hold || k == inj;
            bus.tx_data = hold ? nxt : 8'($urandom);
            @(negedge clk_3125);
        end
        chk({nm, " frame"}, 32'(fr), 32'(exp));
        chk({nm, " rx_msg"}, 32'(fr[9:2]), 32'(exp[9:2]));
        chk({nm, " rx_parity"}, 32'(fr[1]), 32'(^exp[9:2]));
        chk({nm, " bit stability"}, unstable, 0);
        chk({nm, " busy clocks"}, busy_n, FLEN);
        chk({nm, " done count"}, done_n, 1);
        chk({nm, " done position"}, done_at, FLEN - 1);
        chk({nm, " ready"}, ready_bad, 0);
    endtask
    task automatic send(input logic [7:0] b);
        bus.tx_start = 1'b1;
        bus.tx_data = b;
        @(negedge clk_3125);
    endtask
    initial begin
        vecs[0] = '{8'h41, 11'h105, 1'b0};
        vecs[1] = '{8'h07, 11'h01F, 1'b1};
        vecs[2] = '{8'hFF, 11'h3FD, 1'b0};
        vecs[3] = '{8'h00, 11'h001, 1'b0};
        vecs[4] = '{8'hA5, 11'h295, 1'b0};
        vecs[5] = '{8'h3C, 11'h0F1, 1'b0};
        vecs[6] = '{8'h3F, 11'h0FD, 1'b0};
        vecs[7] = '{8'h80, 11'h203, 1'b1};
        vecs[8] = '{8'hC3, 11'h30D, 1'b0};
        rst = 1'b1;
        bus.tx_start = 1'b1;
        bus.tx_data = 8'h5A;
        repeat (3) @(negedge clk_3125);
        chk_idle("reset state");
        rst = 1'b0;
        bus.tx_start = 1'b0;
        repeat (20) begin
            @(negedge clk_3125);
            chk_idle("idle after reset");
        end
        foreach (vecs[i]) begin
            chk($sformatf("vec %0h parity", vecs[i].data), 32'(vecs[i].frame[1]), 32'(vecs[i].par));
            send(vecs[i].data);
            run_frame($sformatf("vec %0h", vecs[i].data), vecs[i].frame, 1'b0, 8'h00, -1);
            chk_idle("idle after frame");
            repeat (3) @(negedge clk_3125);
        end
        send(8'h07);
        run_frame("b2b 07", 11'h01F, 1'b1, 8'hFF, -1);
        run_frame("b2b FF", 11'h3FD, 1'b0, 8'h00, -1);
        chk_idle("idle after b2b");
        send(8'h00);
        run_frame("ignored 55", 11'h001, 1'b0, 8'h00, 70);
        repeat (20) begin
            chk_idle("no second frame");
            @(negedge clk_3125);
        end
        send(8'hA5);
        bus.tx_start = 1'b0;
        repeat (59) @(negedge clk_3125);
        rst = 1'b1;
        @(negedge clk_3125);
        rst = 1'b0;
        chk_idle("abort by reset");
        begin
            int bad = 0;
            repeat (200) begin
                if (bus.tx_done !== 1'b0 || bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
                @(negedge clk_3125);
            end
            chk("quiet after abort", bad, 0);
        end
        send(8'h3C);
        run_frame("after abort 3C", 11'h0F1, 1'b0, 8'h00, -1);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b = 8'($urandom);
            int inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FLEN - 5)) : -1;
            repeat ($urandom_range(0, 5)) begin
                chk_idle("random gap");
                @(negedge clk_3125);
            end
            send(b);
            run_frame($sformatf("rand %0h", b), model(b), 1'b0, 8'h00, inj);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
